spi_slave: RTL

- SPI responder (slave) for the team's SPI master.
- Fully synchronous to the local i_clk. SCLK, SS_N and MOSI are oversampled through 2-FF synchronizers, so the block never uses SCLK as a clock.
- Each frame:
  - shifts BITS bits in from MOSI into a received word;
  - shifts a pre-loaded transmit word out on MISO;
  - hands the received word to local logic with a one-cycle valid pulse.
- Protocol:
  - MSB first.
  - MOSI is sampled on SCLK rising edge.
  - MISO changes on SCLK falling edge.
  - SS_N is active-low.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_slave_if.sv | 22 ++
 rtl/sync_edge.sv | 35 +++
 rtl/spi_slave.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

  localparam int SYNC_DEPTH = 2;
  localparam int DEF_BITS   = 21;
endpackage

// File: rtl/spi_slave_if.sv
// Local-side transmit/receive handshake of the SPI responder.
// tx: a word transfers on a cycle where i_tx_valid & o_tx_ready are both 1;
// rx: o_rx_valid is a one-cycle pulse, with no back-pressure from the consumer.
interface spi_slave_if #(
  parameter int BITS = spi_pkg::DEF_BITS
);
  logic [BITS-1:0] i_tx_data;
  logic            i_tx_valid;
  logic            o_tx_ready;
  logic [BITS-1:0] o_rx_data;
  logic            o_rx_valid;

  modport slave (
    input  i_tx_data, i_tx_valid,
    output o_tx_ready, o_rx_data, o_rx_valid
  );

  modport master (
    output i_tx_data, i_tx_valid,
    input  o_tx_ready, o_rx_data, o_rx_valid
  );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a history flop for rise/fall detection.
module sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], i_pin};
    prev_d = sync_q[SYNC_DEPTH-1];
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= {SYNC_DEPTH{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_level = sync_q[SYNC_DEPTH-1];
  assign o_rise  = o_level & ~prev_q;
  assign o_fall  = ~o_level & prev_q;
endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0, MSB first, oversampled entirely in the i_clk domain.
// A single-entry tx buffer feeds the shift register at each frame start.
module spi_slave
  import spi_pkg::*;
#(
  parameter int BITS  = DEF_BITS,
  parameter int CNT_W = $clog2(BITS) + 1
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_sclk,
  input  logic   i_ss_n,
  input  logic   i_mosi,
  output logic   o_miso,
  output logic   o_miso_oe,
  output logic   o_busy,
  output logic   o_frame_err,
  output logic   o_underrun,
  output state_t o_dbg_state,
  spi_slave_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_sclk),
    .o_level(sclk_lvl), .o_rise(sclk_rise), .o_fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_ss_n),
    .o_level(ss_lvl), .o_rise(ss_rise), .o_fall(ss_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_mosi),
    .o_level(mosi_lvl), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [BITS-1:0]   buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic [BITS-1:0]   rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              underrun_q, underrun_d;
  logic              capture;

  // Only an empty buffer accepts, so a capture coincident with ss_fall is
  // necessarily kept for the following frame.
  assign capture = bus.i_tx_valid & ~buf_full_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    underrun_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
          oe_d    = 1'b1;
          if (buf_full_q) begin
            tx_shift_d = buf_q;
            miso_d     = buf_q[BITS-1];
            buf_full_d = 1'b0;
          end else begin
            tx_shift_d = '0;
            miso_d     = 1'b0;
            underrun_d = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[BITS-2:0], mosi_lvl};
          if (cnt_q < CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (sclk_fall && (cnt_q != '0) && (cnt_q < CNT_FULL)) begin
          tx_shift_d = tx_shift_q << 1;
          miso_d     = tx_shift_q[BITS-2];
        end
        // SCLK work above is kept; DONE then judges the updated count.
        if (ss_rise) begin
          state_d = ST_DONE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end
      end
      ST_DONE: begin
        if (cnt_q == CNT_FULL) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      buf_d      = bus.i_tx_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_miso         = miso_q;
  assign o_miso_oe      = oe_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_frame_err    = frame_err_q;
  assign o_underrun     = underrun_q;
  assign o_dbg_state    = state_q;
  assign bus.o_tx_ready = ~buf_full_q;
  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
endmodule
